// File: rtl/dmem_requester.sv
// rtl/dmem_requester.sv - pipeline-side load/store initiator for the data_mem interface
// One request in flight: issue a one-cycle strobe, track clk_stall, return data or error.
module dmem_requester #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int STALL_GUARD    = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  output logic        mem_memwrite,
  output logic        mem_memread,
  output logic [3:0]  mem_sign_mask,
  input  logic [31:0] mem_read_data,
  input  logic        mem_clk_stall
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] GUARD = CW'(STALL_GUARD);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          is_write;
  logic          req_fire;
  logic          misaligned;
  logic [2:0]    size_mask;

  assign req_fire = req_valid && req_ready;

  always_comb begin
    misaligned = 1'b0;
    size_mask  = 3'b111;
    case (req_size)
      2'b00: size_mask = 3'b001;
      2'b01: begin
        size_mask  = 3'b011;
        misaligned = req_addr[0];
      end
      2'b10: begin
        size_mask  = 3'b111;
        misaligned = (req_addr[1:0] != 2'b00);
      end
      default: begin
        size_mask  = 3'b111;
        misaligned = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      cnt            <= '0;
      is_write       <= 1'b0;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_err       <= 1'b0;
      mem_addr       <= '0;
      mem_write_data <= '0;
      mem_memwrite   <= 1'b0;
      mem_memread    <= 1'b0;
      mem_sign_mask  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_fire) begin
            req_ready      <= 1'b0;
            is_write       <= req_write;
            mem_addr       <= req_addr;
            mem_write_data <= req_wdata;
            mem_sign_mask  <= {req_signed && !req_write, size_mask};
            if (misaligned) begin
              // Rejected requests never reach data_mem.
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state        <= S_ISSUE;
              mem_memwrite <= req_write;
              mem_memread  <= !req_write;
            end
          end
        end
        S_ISSUE: begin
          mem_memwrite <= 1'b0;
          mem_memread  <= 1'b0;
          cnt          <= '0;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          cnt <= cnt + 1'b1;
          // data_mem needs STALL_GUARD cycles before its stall flag is trustworthy.
          if (cnt >= GUARD && !mem_clk_stall) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= is_write ? 32'h0 : mem_read_data;
          end else if (cnt == LAST) begin
            state      <= S_RESP;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
            resp_rdata <= '0;
          end
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            req_ready  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_requester.sv
// tb/tb_dmem_requester.sv - directed vector bench for dmem_requester
module tb_dmem_requester;
  localparam int TIMEOUT = 64;
  localparam int SG      = 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        req_ready;
  logic        resp_valid, resp_err, resp_ready;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_write_data, mem_read_data;
  logic        mem_memwrite, mem_memread, mem_clk_stall;
  logic [3:0]  mem_sign_mask;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_requester #(.TIMEOUT_CYCLES(TIMEOUT), .STALL_GUARD(SG)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err),
    .mem_addr(mem_addr), .mem_write_data(mem_write_data),
    .mem_memwrite(mem_memwrite), .mem_memread(mem_memread),
    .mem_sign_mask(mem_sign_mask), .mem_read_data(mem_read_data),
    .mem_clk_stall(mem_clk_stall)
  );

  typedef struct {
    logic        write;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rd;
    int          stall;
    int          hold;
    logic        exp_strobe;
    logic [3:0]  exp_mask;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input int idx, input vec_t v);
    int nw, nr, lat, k;
    bit stable, done;
    logic [31:0] rd_first;
    @(negedge clk);
    check($sformatf("v%0d req_ready_idle", idx), 32'(req_ready), 32'd1);
    req_valid     = 1'b1;
    req_write     = v.write;
    req_size      = v.size;
    req_signed    = v.sgn;
    req_addr      = v.addr;
    req_wdata     = v.wdata;
    mem_read_data = v.mem_rd;
    mem_clk_stall = (v.stall > 0);
    @(posedge clk);
    nw = 0; nr = 0; lat = 0; stable = 1'b1; done = 1'b0;
    for (k = 1; k <= 200 && !done; k++) begin
      @(negedge clk);
      req_valid = 1'b0;
      nw += int'(mem_memwrite);
      nr += int'(mem_memread);
      if (mem_memwrite && mem_memread) stable = 1'b0;
      if (mem_addr !== v.addr || mem_write_data !== v.wdata) stable = 1'b0;
      if (k > 1 && req_ready !== 1'b0) stable = 1'b0;
      if (resp_valid) begin
        done = 1'b1;
        lat  = k;
      end else if (k == v.stall) begin
        mem_clk_stall = 1'b0;
      end
    end
    mem_clk_stall = 1'b0;
    check($sformatf("v%0d resp_arrived", idx), 32'(done), 32'd1);
    check($sformatf("v%0d memwrite_pulses", idx), 32'(nw), 32'(v.exp_strobe && v.write));
    check($sformatf("v%0d memread_pulses", idx), 32'(nr), 32'(v.exp_strobe && !v.write));
    check($sformatf("v%0d addr_data_stable", idx), 32'(stable), 32'd1);
    if (v.size != 2'b11)
      check($sformatf("v%0d sign_mask", idx), 32'(mem_sign_mask), 32'(v.exp_mask));
    check($sformatf("v%0d resp_err", idx), 32'(resp_err), 32'(v.exp_err));
    check($sformatf("v%0d resp_rdata", idx), resp_rdata, v.exp_rdata);
    if (v.exp_lat > 0)
      check($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
    rd_first = resp_rdata;
    stable = 1'b1;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      if (!resp_valid || resp_rdata !== rd_first || resp_err !== v.exp_err || req_ready) stable = 1'b0;
    end
    if (v.hold > 0)
      check($sformatf("v%0d resp_held", idx), 32'(stable), 32'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check($sformatf("v%0d resp_valid_drop", idx), 32'(resp_valid), 32'd0);
    check($sformatf("v%0d req_ready_back", idx), 32'(req_ready), 32'd1);
  endtask

  vec_t vecs[$];
  bit   quiet;

  initial begin
    // Aligned, unstalled accesses see resp_valid at the negedge following edge 2+SG after accept.
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h400, 32'h0AAA,     32'h0,        0,    0, 1'b1, 4'b0001, 1'b0, 32'h0,        3+SG});
    vecs.push_back('{1'b0, 2'b00, 1'b1, 32'h400, 32'h0,        32'hFFFFFFAA, 0,    0, 1'b1, 4'b1001, 1'b0, 32'hFFFFFFAA, 3+SG});
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h400, 32'h0,        32'h000000AA, 0,    0, 1'b1, 4'b0001, 1'b0, 32'h000000AA, 3+SG});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h100, 32'h2AAAA,    32'h0,        0,    0, 1'b1, 4'b0011, 1'b0, 32'h0,        3+SG});
    vecs.push_back('{1'b0, 2'b01, 1'b1, 32'h100, 32'h0,        32'hFFFFAAAA, 0,    0, 1'b1, 4'b1011, 1'b0, 32'hFFFFAAAA, 3+SG});
    vecs.push_back('{1'b1, 2'b10, 1'b0, 32'h40,  32'hAAAAAAAA, 32'h0,        0,    0, 1'b1, 4'b0111, 1'b0, 32'h0,        3+SG});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h40,  32'h0,        32'hAAAAAAAA, 0,    0, 1'b1, 4'b0111, 1'b0, 32'hAAAAAAAA, 3+SG});
    vecs.push_back('{1'b0, 2'b10, 1'b0, 32'h42,  32'h0,        32'h12345678, 0,    0, 1'b0, 4'b0111, 1'b1, 32'h0,        0});
    vecs.push_back('{1'b1, 2'b01, 1'b0, 32'h101, 32'h1234,     32'h0,        0,    0, 1'b0, 4'b0011, 1'b1, 32'h0,        0});
    vecs.push_back('{1'b0, 2'b11, 1'b1, 32'h200, 32'h0,        32'h87654321, 0,    0, 1'b0, 4'b0000, 1'b1, 32'h0,        0});
    // Stall released at negedge 22 after accept: response one cycle later.
    vecs.push_back('{1'b0, 2'b00, 1'b0, 32'h403, 32'h0,        32'h0000005A, 22,   5, 1'b1, 4'b0001, 1'b0, 32'h0000005A, 23});
    // Stall never released: timeout after TIMEOUT WAIT cycles.
    vecs.push_back('{1'b0, 2'b10, 1'b1, 32'h80,  32'h0,        32'hDEADBEEF, 1000, 0, 1'b1, 4'b1111, 1'b1, 32'h0,        TIMEOUT+2});
    vecs.push_back('{1'b1, 2'b00, 1'b0, 32'h7,   32'h55,       32'h0,        0,    5, 1'b1, 4'b0001, 1'b0, 32'h0,        3+SG});

    rst_n = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    mem_read_data = '0; mem_clk_stall = 1'b0;
    @(negedge clk);
    check("reset req_ready", 32'(req_ready), 32'd1);
    check("reset resp_valid", 32'(resp_valid), 32'd0);
    check("reset strobes", 32'({mem_memwrite, mem_memread}), 32'd0);
    check("reset mem_addr", mem_addr, 32'h0);
    check("reset sign_mask", 32'(mem_sign_mask), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) run_txn(i, vecs[i]);

    // Reset pulsed mid-WAIT: everything clears at once, no response ever appears.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_signed = 1'b1;
    req_addr = 32'h300; mem_read_data = 32'hCAFEF00D; mem_clk_stall = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst resp_valid", 32'(resp_valid), 32'd0);
    check("midrst strobes", 32'({mem_memwrite, mem_memread}), 32'd0);
    check("midrst mem_addr", mem_addr, 32'h0);
    check("midrst sign_mask", 32'(mem_sign_mask), 32'd0);
    @(negedge clk);
    mem_clk_stall = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst req_ready", 32'(req_ready), 32'd1);
    quiet = 1'b1;
    repeat (8) begin
      @(negedge clk);
      if (resp_valid) quiet = 1'b0;
    end
    check("midrst no_response", 32'(quiet), 32'd1);
    run_txn(99, vecs[1]);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end
endmodule
